// File: rtl/pip_mult_stream.sv
`default_nettype none
//============================================================================
//  Module      : pip_mult_stream
//  Description : Pipelined shift-and-add multiplier with valid/ready
//                streaming. Stage 1 registers W partial products, stages
//                2..LAT reduce them with a binary adder tree. Each beat
//                selects unsigned or two's-complement operands and carries
//                a sideband tag. Per-stage valid bits let bubbles collapse
//                while the output is stalled.
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
//  Parameters
//    W          operand width, power of two, 2..32
//    TAG_W      sideband tag width, >= 1
//  Ports
//    clk        clock, rising edge
//    rst        asynchronous active-high reset
//    clr        synchronous flush of all in-flight beats
//    in_valid   operand beat valid
//    in_ready   pipe can accept a beat this cycle
//    in_signed  1 = a,b two's complement, 0 = unsigned
//    a, b       multiplicand / multiplier
//    in_tag     sideband returned unchanged with the product
//    out_valid  product valid
//    out_ready  consumer accepts product
//    product    full 2W-bit product
//    out_tag    tag of the product beat
//============================================================================
module pip_mult_stream #(
    parameter int W     = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     product,
    output logic [TAG_W-1:0]   out_tag
);

    // Pipeline depth: one partial-product stage plus log2(W) adder levels.
    localparam int LAT = 1 + $clog2(W);

    // All adder-tree terms live in one heap-like array. Stage s (0-based)
    // holds W>>s terms starting at offset 2W - 2*(W>>s); the final stage
    // is the single term at index 2W-2.
    localparam int c_nterms = 2 * W - 1;

    logic [LAT-1:0]     r_valid;
    logic [TAG_W-1:0]   r_tag  [LAT];
    logic [2*W-1:0]     r_term [c_nterms];

    logic [LAT:0]       w_ready;
    logic [2*W-1:0]     w_a_ext;
    logic [2*W-1:0]     w_pp   [W];

    //------------------------------------------------------------------
    // Ready chain. ready[s] = !v[s] || ready[s+1] unrolled into its
    // closed form: a stage can load unless it and every stage downstream
    // of it are full while the consumer stalls. Written this way each bit
    // depends only on registers and out_ready, never on another ready bit.
    //------------------------------------------------------------------
    assign w_ready[LAT] = out_ready;

    generate
        for (genvar s = 0; s < LAT; s++) begin : g_ready
            assign w_ready[s] = out_ready | ~(&r_valid[LAT-1:s]);
        end
    endgenerate

    assign in_ready = w_ready[0];

    //------------------------------------------------------------------
    // Partial products. In signed mode a is sign-extended to 2W and the
    // MSB of b carries weight -2^(W-1), so its row is negated. All
    // arithmetic wraps modulo 2^(2W).
    //------------------------------------------------------------------
    assign w_a_ext = in_signed ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};

    generate
        for (genvar i = 0; i < W; i++) begin : g_pp
            logic [2*W-1:0] w_shift;
            assign w_shift = w_a_ext << i;

            if (i == W - 1) begin : g_msb
                assign w_pp[i] = b[i] ? (in_signed ? -w_shift : w_shift)
                                      : '0;
            end else begin : g_low
                assign w_pp[i] = b[i] ? w_shift : '0;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_term[i] <= '0;
                end else if (w_ready[0]) begin
                    r_term[i] <= w_pp[i];
                end
            end
        end
    endgenerate

    //------------------------------------------------------------------
    // Adder tree: term j of stage s is the sum of terms 2j and 2j+1 of
    // stage s-1. Data follows its stage's ready so a stalled stage holds.
    //------------------------------------------------------------------
    generate
        for (genvar s = 1; s < LAT; s++) begin : g_tree
            for (genvar j = 0; j < (W >> s); j++) begin : g_add
                localparam int c_dst = 2 * W - 2 * (W >> s) + j;
                localparam int c_src = 2 * W - 2 * (W >> (s - 1)) + 2 * j;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_term[c_dst] <= '0;
                    end else if (w_ready[s]) begin
                        r_term[c_dst] <= r_term[c_src] + r_term[c_src+1];
                    end
                end
            end
        end
    endgenerate

    //------------------------------------------------------------------
    // Valid and tag per stage. clr wins over any load, so a beat offered
    // alongside clr is discarded and nothing in flight survives.
    //------------------------------------------------------------------
    generate
        for (genvar s = 0; s < LAT; s++) begin : g_stage
            if (s == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_valid[0] <= 1'b0;
                        r_tag[0]   <= '0;
                    end else begin
                        // With ready[0] high, in_valid equals accept.
                        if (clr) begin
                            r_valid[0] <= 1'b0;
                        end else if (w_ready[0]) begin
                            r_valid[0] <= in_valid;
                        end
                        if (w_ready[0]) begin
                            r_tag[0] <= in_tag;
                        end
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_valid[s] <= 1'b0;
                        r_tag[s]   <= '0;
                    end else begin
                        if (clr) begin
                            r_valid[s] <= 1'b0;
                        end else if (w_ready[s]) begin
                            r_valid[s] <= r_valid[s-1];
                        end
                        if (w_ready[s]) begin
                            r_tag[s] <= r_tag[s-1];
                        end
                    end
                end
            end
        end
    endgenerate

    // The last tree stage drives the output port directly.
    assign out_valid = r_valid[LAT-1];
    assign product   = r_term[c_nterms-1];
    assign out_tag   = r_tag[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_pip_mult_stream.sv
`default_nettype none
//============================================================================
//  Module      : tb_pip_mult_stream
//  Description : Directed self-checking bench for pip_mult_stream (W=8,
//                TAG_W=4). Inputs change 1 ns after the rising edge and
//                outputs are checked there, away from the active edge.
//  Revision    : 1.0 - initial release
//============================================================================
module tb_pip_mult_stream;

    localparam int W     = 8;
    localparam int TAG_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               clr;
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*W-1:0]     product;
    logic [TAG_W-1:0]   out_tag;

    int   total = 0;
    int   bad   = 0;
    int   idx;
    int   out_n;
    int   ones;
    logic acc_now;

    // Backpressure vectors: products worked out by hand.
    logic [7:0]  bp_a [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic [7:0]  bp_b [6] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    logic [31:0] bp_p [6] = '{32'd3, 32'd8, 32'd15, 32'd24, 32'd35, 32'd48};

    always #5 clk = ~clk;

    pip_mult_stream #(.W(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sg, input logic [7:0] av,
                         input logic [7:0] bv, input logic [3:0] tg);
        in_valid  = v;
        in_signed = sg;
        a         = av;
        b         = bv;
        in_tag    = tg;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 8'd0, 4'd0);

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product",   32'(product),   32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // 255*255 unsigned, latency exactly 4 cycles
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 4'd1);
        #1;
        check("t1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check("t1_early_valid", 32'(out_valid), 32'd0);
            tick();
        end
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_product",   32'(product),   32'hFE01);
        check("t1_tag",       32'(out_tag),   32'd1);
        tick();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Signed, back-to-back
        drive(1'b1, 1'b1, 8'h80, 8'h80, 4'd1); tick();
        drive(1'b1, 1'b1, 8'hFF, 8'h7F, 4'd2); tick();
        drive(1'b1, 1'b1, 8'h7F, 8'h80, 4'd3); tick();
        in_valid = 1'b0;
        tick();
        check("t2_p0", 32'(product), 32'h4000);
        check("t2_v0", 32'(out_valid), 32'd1);
        tick();
        check("t2_p1", 32'(product), 32'hFF81);
        check("t2_t1", 32'(out_tag), 32'd2);
        tick();
        check("t2_p2", 32'(product), 32'hC080);
        check("t2_t2", 32'(out_tag), 32'd3);
        tick();
        check("t2_drained", 32'(out_valid), 32'd0);

        // Mixed mode: same operands, unsigned then signed
        drive(1'b1, 1'b0, 8'hFF, 8'h02, 4'd3); tick();
        drive(1'b1, 1'b1, 8'hFF, 8'h02, 4'd4); tick();
        in_valid = 1'b0;
        tick(); tick();
        check("t3_p_unsigned", 32'(product), 32'h01FE);
        check("t3_tag3",       32'(out_tag), 32'd3);
        tick();
        check("t3_p_signed", 32'(product), 32'hFFFE);
        check("t3_tag4",     32'(out_tag), 32'd4);
        tick();

        // Backpressure: 6 beats with out_ready low
        out_ready = 1'b0;
        idx = 0;
        repeat (8) begin
            if (idx < 6) drive(1'b1, 1'b0, bp_a[idx], bp_b[idx], 4'(idx));
            else         in_valid = 1'b0;
            #1;
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) idx++;
        end
        check("t4_accepts", 32'(idx), 32'd4);
        #1;
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_out_valid",    32'(out_valid), 32'd1);
        check("t4_head_product", 32'(product), 32'd3);
        repeat (2) begin
            tick();
            check("t4_hold_product", 32'(product), 32'd3);
            check("t4_hold_tag",     32'(out_tag), 32'd0);
        end
        out_ready = 1'b1;
        out_n = 0;
        for (int c = 0; c < 20 && out_n < 6; c++) begin
            if (idx < 6) drive(1'b1, 1'b0, bp_a[idx], bp_b[idx], 4'(idx));
            else         in_valid = 1'b0;
            #1;
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                check("t4_order_product", 32'(product), bp_p[out_n]);
                check("t4_order_tag",     32'(out_tag), 32'(out_n));
                out_n++;
            end
            tick();
            if (acc_now) idx++;
        end
        check("t4_all_out", 32'(out_n), 32'd6);
        check("t4_all_in",  32'(idx),   32'd6);
        in_valid = 1'b0;
        ones = 0;
        repeat (6) begin
            tick();
            if (out_valid) ones++;
        end
        check("t4_no_dup", 32'(ones), 32'd0);

        // Bubble compression
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'd10, 8'd10, 4'd5); tick();
        in_valid = 1'b0;                         tick();
        drive(1'b1, 1'b0, 8'd12, 8'd11, 4'd6); tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("t5_in_ready_partial", 32'(in_ready), 32'd1);
        tick();
        check("t5_v0", 32'(out_valid), 32'd1);
        check("t5_p0", 32'(product),   32'd100);
        out_ready = 1'b1;
        tick();
        check("t5_v1", 32'(out_valid), 32'd1);
        check("t5_p1", 32'(product),   32'd132);
        check("t5_t1", 32'(out_tag),   32'd6);
        tick();
        check("t5_drained", 32'(out_valid), 32'd0);

        // Async reset with beats in flight
        drive(1'b1, 1'b0, 8'd3, 8'd3, 4'd1); tick();
        drive(1'b1, 1'b0, 8'd4, 8'd4, 4'd2); tick();
        drive(1'b1, 1'b0, 8'd5, 8'd5, 4'd3); tick();
        in_valid = 1'b0;
        tick();
        check("t6_pre_valid",   32'(out_valid), 32'd1);
        check("t6_pre_product", 32'(product),   32'd9);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid",   32'(out_valid), 32'd0);
        check("t6_rst_product", 32'(product),   32'd0);
        check("t6_rst_tag",     32'(out_tag),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ones = 0;
        repeat (8) begin
            tick();
            if (out_valid) ones++;
        end
        check("t6_no_stale", 32'(ones), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);

        // clr with beats in flight, plus a beat offered during clr
        drive(1'b1, 1'b0, 8'd2, 8'd2, 4'd7); tick();
        drive(1'b1, 1'b0, 8'd3, 8'd2, 4'd8); tick();
        drive(1'b1, 1'b0, 8'd4, 8'd2, 4'd9); tick();
        drive(1'b1, 1'b0, 8'd9, 8'd9, 4'd10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        ones = 0;
        repeat (8) begin
            if (out_valid) ones++;
            tick();
        end
        check("t6_clr_nothing", 32'(ones), 32'd0);
        drive(1'b1, 1'b0, 8'd7, 8'd6, 4'd2); tick();
        in_valid = 1'b0;
        tick(); tick();
        check("t6_post_clr_early", 32'(out_valid), 32'd0);
        tick();
        check("t6_post_clr_valid",   32'(out_valid), 32'd1);
        check("t6_post_clr_product", 32'(product),   32'd42);
        check("t6_post_clr_tag",     32'(out_tag),   32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
